// File: rtl/spi_avmm_pkg.sv
// Shared types and framing constants for the SPI-to-Avalon-MM slave bridge.
package spi_avmm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_DUMMY,
        RD_DATA
    } state_t;

    localparam int CMD_BITS   = 8;
    localparam int WORD_BITS  = 32;
    localparam int DUMMY_BITS = 8;
    localparam int RW_BIT     = 7;

endpackage

// File: rtl/spi_avmm_slave_bridge_if.sv
// Avalon-MM master bus between the SPI bridge and the fabric interconnect.
interface spi_avmm_slave_bridge_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface

// File: rtl/spi_in_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags sclk / select edges.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic mosi,
    input  logic ss_n,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic sel,
    output logic sel_rise,
    output logic sel_fall
);
    // One extra flop on sclk and ss_n holds the previous synced sample for edge detection.
    logic [SYNC_STAGES:0]   sclk_p;
    logic [SYNC_STAGES:0]   ss_n_p;
    logic [SYNC_STAGES-1:0] mosi_p;

    // Synchronizer chains, preset to the idle bus (sclk low, slave deselected).
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_p <= '0;
            ss_n_p <= '1;
            mosi_p <= '0;
        end else begin
            sclk_p <= {sclk_p[SYNC_STAGES-1:0], sclk};
            ss_n_p <= {ss_n_p[SYNC_STAGES-1:0], ss_n};
            mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi};
        end
    end

    // mosi_s is taken from the same stage as the sclk sample that flags the rise.
    assign mosi_s    = mosi_p[SYNC_STAGES-1];
    assign sclk_rise =  sclk_p[SYNC_STAGES-1] & ~sclk_p[SYNC_STAGES];
    assign sclk_fall = ~sclk_p[SYNC_STAGES-1] &  sclk_p[SYNC_STAGES];
    assign sel       = ~ss_n_p[SYNC_STAGES-1];
    assign sel_rise  = ~ss_n_p[SYNC_STAGES-1] &  ss_n_p[SYNC_STAGES];
    assign sel_fall  =  ss_n_p[SYNC_STAGES-1] & ~ss_n_p[SYNC_STAGES];

endmodule

// File: rtl/spi_avmm_slave_bridge.sv
// SPI mode-0 slave that turns each frame into 32-bit Avalon-MM reads or writes.
module spi_avmm_slave_bridge
    import spi_avmm_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_sclk,
    input  logic spi_mosi,
    input  logic spi_ss_n,
    output logic spi_miso,
    output logic spi_miso_oe,
    spi_avmm_slave_bridge_if.master avm,
    output logic err_overrun,
    output logic err_underrun
);
    localparam int WA_W = ADDR_W - 2;
    typedef logic [WA_W-1:0] waddr_t;

    localparam logic [5:0] CMD_LAST   = 6'(CMD_BITS - 1);
    localparam logic [5:0] WORD_LAST  = 6'(WORD_BITS - 1);
    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_BITS - 1);

    logic mosi_s, sclk_rise, sclk_fall, sel, sel_rise, sel_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .ss_n      (spi_ss_n),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .sel       (sel),
        .sel_rise  (sel_rise),
        .sel_fall  (sel_fall)
    );

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [30:0] shift_in;
    logic [30:0] shift_out;
    logic [31:0] hold;
    logic        hold_valid;
    logic        rd_out;       // read accepted, data not yet returned
    logic        rd_discard;   // the in-flight read belongs to a dead word or frame
    logic        rd_want;      // a prefetch is owed but the bus was busy
    waddr_t      word_addr;
    logic        miso_q;
    logic        oe_q;

    logic [31:0] shift_in_nxt;
    logic [7:0]  cmd_byte;
    waddr_t      cmd_addr;
    waddr_t      word_addr_inc;
    logic        rd_busy;
    logic        can_read;
    logic        bus_stalled;

    assign shift_in_nxt  = {shift_in, mosi_s};
    assign cmd_byte      = shift_in_nxt[CMD_BITS-1:0];
    assign cmd_addr      = waddr_t'(cmd_byte[RW_BIT-1:0]);
    assign word_addr_inc = word_addr + 1'b1;
    // A read returning this cycle no longer counts as outstanding.
    assign rd_busy       = avm.avm_read | (rd_out & ~avm.avm_readdatavalid);
    assign can_read      = ~rd_busy & ~(avm.avm_write & avm.avm_waitrequest);
    assign bus_stalled   = (avm.avm_write | avm.avm_read) & avm.avm_waitrequest;

    assign avm.avm_byteenable = 4'hF;
    assign spi_miso           = miso_q;
    assign spi_miso_oe        = oe_q;

    // Frame FSM, Avalon command handshake and read prefetch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            bit_cnt           <= '0;
            word_addr         <= '0;
            hold_valid        <= 1'b0;
            rd_out            <= 1'b0;
            rd_discard        <= 1'b0;
            rd_want           <= 1'b0;
            miso_q            <= 1'b0;
            oe_q              <= 1'b0;
            err_overrun       <= 1'b0;
            err_underrun      <= 1'b0;
            avm.avm_read      <= 1'b0;
            avm.avm_write     <= 1'b0;
            avm.avm_address   <= '0;
            avm.avm_writedata <= '0;
        end else begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
            oe_q         <= sel;

            // Command completion; these run regardless of the frame state.
            if (avm.avm_write && !avm.avm_waitrequest) begin
                avm.avm_write <= 1'b0;
            end
            if (avm.avm_read && !avm.avm_waitrequest) begin
                avm.avm_read <= 1'b0;
                rd_out       <= 1'b1;
            end
            if (rd_out && avm.avm_readdatavalid) begin
                rd_out     <= 1'b0;
                rd_discard <= 1'b0;
                if (!rd_discard && state != IDLE) begin
                    hold       <= avm.avm_readdata;
                    hold_valid <= 1'b1;
                end
            end

            // Issue a prefetch that had to wait for the bus to drain.
            if (rd_want && can_read && (state == RD_DUMMY || state == RD_DATA)) begin
                avm.avm_read    <= 1'b1;
                avm.avm_address <= {word_addr, 2'b00};
                rd_want         <= 1'b0;
            end

            if (sel_fall) begin
                state   <= IDLE;
                bit_cnt <= '0;
                rd_want <= 1'b0;
                miso_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_rise) begin
                            state      <= CMD;
                            bit_cnt    <= '0;
                            hold_valid <= 1'b0;
                            rd_discard <= rd_busy;
                            rd_want    <= 1'b0;
                            miso_q     <= 1'b0;
                        end
                    end

                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= shift_in_nxt[30:0];
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt   <= '0;
                                word_addr <= cmd_addr;
                                if (cmd_byte[RW_BIT]) begin
                                    state <= RD_DUMMY;
                                    if (can_read) begin
                                        avm.avm_read    <= 1'b1;
                                        avm.avm_address <= {cmd_addr, 2'b00};
                                    end else begin
                                        rd_want <= 1'b1;
                                    end
                                end else begin
                                    state <= WR_DATA;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end

                    WR_DATA: begin
                        if (sclk_rise) begin
                            shift_in <= shift_in_nxt[30:0];
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt   <= '0;
                                word_addr <= word_addr_inc;
                                if (bus_stalled) begin
                                    err_overrun <= 1'b1;
                                end else begin
                                    avm.avm_write     <= 1'b1;
                                    avm.avm_address   <= {word_addr, 2'b00};
                                    avm.avm_writedata <= shift_in_nxt;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end

                    RD_DUMMY: begin
                        if (sclk_rise) begin
                            if (bit_cnt == DUMMY_LAST) begin
                                bit_cnt <= '0;
                                state   <= RD_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end

                    RD_DATA: begin
                        if (sclk_rise) begin
                            bit_cnt <= (bit_cnt == WORD_LAST) ? 6'd0 : bit_cnt + 6'd1;
                        end else if (sclk_fall) begin
                            if (bit_cnt == 6'd0) begin
                                // Word boundary: present the prefetched word, fetch the next one.
                                word_addr  <= word_addr_inc;
                                hold_valid <= 1'b0;
                                if (hold_valid) begin
                                    shift_out <= hold[30:0];
                                    miso_q    <= hold[31];
                                end else begin
                                    shift_out    <= '0;
                                    miso_q       <= 1'b0;
                                    err_underrun <= 1'b1;
                                    if (rd_busy) begin
                                        rd_discard <= 1'b1;
                                    end
                                end
                                if (can_read) begin
                                    avm.avm_read    <= 1'b1;
                                    avm.avm_address <= {word_addr_inc, 2'b00};
                                    rd_want         <= 1'b0;
                                end else begin
                                    rd_want <= 1'b1;
                                end
                            end else begin
                                shift_out <= {shift_out[29:0], 1'b0};
                                miso_q    <= shift_out[30];
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
